// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: fixed display fetch slots with a req/ack CPU port in the gaps.
// Optional frame_irq output when VGA_FB_ARB_FRAME_IRQ_EN is defined.
module vga_fb_arbiter #(
    parameter int FB_W   = 160,
    parameter int FB_H   = 120,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        x,
    input  logic [8:0]        y,
    output logic              RD,
    output logic              GD,
    output logic              BD,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [2:0]        mem_wdata,
    input  logic [2:0]        mem_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [2:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [2:0]        cpu_rdata
`ifdef VGA_FB_ARB_FRAME_IRQ_EN
    ,
    output logic              frame_irq
`endif
);

    localparam int          CALC_W  = (ADDR_W > 15) ? ADDR_W : 15;
    localparam logic [31:0] FB_W_U  = FB_W;
    localparam logic [31:0] FB_H_U  = FB_H;
    localparam logic [31:0] FB_SIZE = FB_W * FB_H;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t state, state_nxt;

    logic [7:0]        col;
    logic [6:0]        row;
    logic              visible;
    logic              slot;
    logic [CALC_W-1:0] disp_full;
    logic              cpu_in_range;
    logic              issue;
    logic              rd_ok_q;
    logic              slot_d1;
    logic [2:0]        pix;
    logic              vis_d1;
    logic              vis_d2;

    assign col       = x[9:2];
    assign row       = y[8:2];
    assign visible   = ({24'b0, col} < FB_W_U) && ({25'b0, row} < FB_H_U);
    assign slot      = visible && (x[1:0] == 2'b00);
    assign disp_full = CALC_W'(row) * CALC_W'(FB_W) + CALC_W'(col);

    assign cpu_in_range = {{(32-ADDR_W){1'b0}}, cpu_addr} < FB_SIZE;

    // Memory port outputs are gated by rst_n so a write strobe drops the moment reset asserts.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (cpu_req && !slot) begin
                    issue     = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (rst_n) begin
            if (slot) begin
                mem_addr = disp_full[ADDR_W-1:0];
            end else if (issue) begin
                mem_addr  = cpu_addr;
                mem_we    = cpu_we && cpu_in_range;
                mem_wdata = cpu_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rd_ok_q <= 1'b0;
            slot_d1 <= 1'b0;
            pix     <= '0;
            vis_d1  <= 1'b0;
            vis_d2  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (issue) begin
                rd_ok_q <= !cpu_we && cpu_in_range;
            end
            slot_d1 <= slot;
            if (slot_d1) begin
                pix <= mem_rdata;
            end
            vis_d1 <= visible;
            vis_d2 <= vis_d1;
        end
    end

    assign cpu_ack      = (state == BUSY);
    assign cpu_rdata    = (cpu_ack && rd_ok_q) ? mem_rdata : '0;
    assign {RD, GD, BD} = vis_d2 ? pix : '0;

`ifdef VGA_FB_ARB_FRAME_IRQ_EN
    localparam logic [31:0] VBLANK_Y = FB_H * 4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_irq <= 1'b0;
        end else begin
            frame_irq <= (x == 10'd0) && ({23'b0, y} == VBLANK_Y);
        end
    end
`else
    logic unused_y_lsbs;
    assign unused_y_lsbs = ^y[1:0];
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: random CPU traffic over scanned lines, checked
// against a pixel-array reference model.
`timescale 1ns/1ps
module tb_vga_fb_arbiter;

    localparam int FB_W    = 160;
    localparam int FB_H    = 120;
    localparam int ADDR_W  = 15;
    localparam int FB_SIZE = FB_W * FB_H;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [9:0]        x     = '0;
    logic [8:0]        y     = '0;
    logic              RD, GD, BD;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [2:0]        mem_wdata;
    logic [2:0]        mem_rdata = '0;
    logic              cpu_req   = 1'b0;
    logic              cpu_we    = 1'b0;
    logic [ADDR_W-1:0] cpu_addr  = '0;
    logic [2:0]        cpu_wdata = '0;
    logic              cpu_ack;
    logic [2:0]        cpu_rdata;
`ifdef VGA_FB_ARB_FRAME_IRQ_EN
    logic              frame_irq;
`endif

    always #5 clk = ~clk;

    vga_fb_arbiter #(.FB_W(FB_W), .FB_H(FB_H), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y),
        .RD(RD), .GD(GD), .BD(BD),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata)
`ifdef VGA_FB_ARB_FRAME_IRQ_EN
        , .frame_irq(frame_irq)
`endif
    );

    // Synchronous-read single-port memory and the bench's own picture of its contents.
    logic [2:0] mem    [0:32767];
    logic [2:0] fb_ref [0:32767];
    initial begin
        for (int i = 0; i < 32768; i++) begin
            mem[i]    = 3'(i);
            fb_ref[i] = 3'(i);
        end
    end
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int         cyc;
        logic [2:0] data;
    } ack_t;

    typedef struct {
        bit         we;
        int         addr;
        logic [2:0] data;
        int         cond;   // 0 any cycle, 1 display slot, 2 blanking
    } cmd_t;

    logic [2:0] cq[$];
    ack_t       aq[$];
    cmd_t       dq[$];
    bit         primed     = 1'b0;
    int         last_issue = -10;
    logic [2:0] cur_pix    = '0;
    bit         irq_exp    = 1'b0;
    int         rand_pct   = 0;
    bit         ack_seen   = 1'b0;

    function automatic bit vis(input int px, input int py);
        return (px / 4 < FB_W) && (py / 4 < FB_H);
    endfunction

    // Reference: display fetch in every visible 4-count group start, CPU served in any other
    // cycle except the one right after its own access; colour appears two cycles later.
    task automatic model_step();
        int a;
        bit in_range, slot_now, v;
        v        = vis(int'(x), int'(y));
        slot_now = v && (int'(x) % 4 == 0);
        if (!primed) begin
            cq.push_back(3'b0);
            cq.push_back(3'b0);
            primed = 1'b1;
        end
        if (slot_now) begin
            a = (int'(y) / 4) * FB_W + int'(x) / 4;
            chk("disp_addr", 32'(mem_addr), 32'(a));
            chk("disp_we", 32'(mem_we), 32'(0));
            cur_pix = fb_ref[a];
        end else if (cpu_req && cyc != last_issue + 1) begin
            a        = int'(cpu_addr);
            in_range = a < FB_SIZE;
            chk("cpu_mem_addr", 32'(mem_addr), 32'(a));
            chk("cpu_mem_we", 32'(mem_we), 32'(cpu_we && in_range));
            if (cpu_we && in_range) chk("cpu_mem_wdata", 32'(mem_wdata), 32'(cpu_wdata));
            aq.push_back('{cyc: cyc + 1, data: (!cpu_we && in_range) ? fb_ref[a] : 3'b0});
            if (cpu_we && in_range) fb_ref[a] = cpu_wdata;
            last_issue = cyc;
        end else begin
            chk("idle_addr", 32'(mem_addr), 32'(0));
            chk("idle_we", 32'(mem_we), 32'(0));
            chk("idle_wdata", 32'(mem_wdata), 32'(0));
        end
        cq.push_back(v ? cur_pix : 3'b0);
`ifdef VGA_FB_ARB_FRAME_IRQ_EN
        chk("frame_irq", 32'(frame_irq), 32'(irq_exp));
        irq_exp = (int'(x) == 0) && (int'(y) == FB_H * 4);
`endif
    endtask

    always begin
        @(posedge clk);
        #3;
        if (rst_n) model_step();
    end

    // Monitor: colour every cycle, CPU responses whenever an ack is due or seen.
    always @(negedge clk) begin
        ack_t e;
        if (rst_n && primed) begin
            if (cq.size() != 0) chk("colour", 32'({RD, GD, BD}), 32'(cq.pop_front()));
            if (aq.size() != 0 && aq[0].cyc <= cyc) begin
                e = aq.pop_front();
                chk("ack_on_time", 32'(cpu_ack), 32'(1));
                chk("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
            end else if (cpu_ack) begin
                chk("unexpected_ack", 32'(cpu_ack), 32'(0));
            end
        end
    end

    task automatic present(input cmd_t c);
        cpu_req   = 1'b1;
        cpu_we    = c.we;
        cpu_addr  = ADDR_W'(c.addr);
        cpu_wdata = c.data;
    endtask

    task automatic tick(input int nx, input int ny);
        cmd_t c;
        bit   ok;
        @(negedge clk);
        ack_seen = cpu_ack;
        @(posedge clk);
        #1;
        x = 10'(nx);
        y = 9'(ny);
        if (cpu_req && ack_seen) cpu_req = 1'b0;
        if (!cpu_req) begin
            if (dq.size() != 0) begin
                ok = (dq[0].cond == 0) ||
                     (dq[0].cond == 1 && vis(nx, ny) && nx % 4 == 0) ||
                     (dq[0].cond == 2 && !vis(nx, ny));
                if (ok) present(dq.pop_front());
            end else if (rand_pct != 0 && $urandom_range(99) < rand_pct) begin
                c.we   = 1'($urandom_range(1));
                c.addr = ($urandom_range(9) == 0) ? int'($urandom_range(32767, FB_SIZE))
                                                  : int'($urandom_range(FB_SIZE - 1));
                c.data = 3'($urandom_range(7));
                c.cond = 0;
                present(c);
            end
        end
    endtask

    task automatic line(input int ny);
        for (int i = 0; i < 800; i++) tick(i, ny);
    endtask

    task automatic enter_reset();
        rst_n      = 1'b0;
        cq.delete();
        aq.delete();
        primed     = 1'b0;
        last_issue = -10;
        cur_pix    = '0;
        irq_exp    = 1'b0;
    endtask

    task automatic drain(input int ny);
        for (int i = 0; i < 100 && (cpu_req || dq.size() != 0); i++) tick(600 + i, ny);
    endtask

    initial begin
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 15'd5;
        cpu_wdata = 3'd7;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_mem_we", 32'(mem_we), 32'(0));
        chk("rst_mem_addr", 32'(mem_addr), 32'(0));
        chk("rst_ack", 32'(cpu_ack), 32'(0));
        chk("rst_rdata", 32'(cpu_rdata), 32'(0));
        chk("rst_rgb", 32'({RD, GD, BD}), 32'(0));
`ifdef VGA_FB_ARB_FRAME_IRQ_EN
        chk("rst_irq", 32'(frame_irq), 32'(0));
`endif
        cpu_req = 1'b0;
        y       = 9'd500;
        @(posedge clk);
        #1 rst_n = 1'b1;

        dq.push_back('{we: 1'b1, addr: 19199, data: 3'b101, cond: 2});
        dq.push_back('{we: 1'b0, addr: 19199, data: 3'b000, cond: 2});
        line(500);
        dq.push_back('{we: 1'b1, addr: 19200, data: 3'b011, cond: 2});
        dq.push_back('{we: 1'b0, addr: 19200, data: 3'b000, cond: 2});
        line(501);
        dq.push_back('{we: 1'b0, addr: 100, data: 3'b000, cond: 1});
        dq.push_back('{we: 1'b1, addr: 200, data: 3'b110, cond: 1});
        dq.push_back('{we: 1'b0, addr: 200, data: 3'b000, cond: 1});
        line(8);

        rand_pct = 30;
        for (int r = 0; r < 8; r++) line(r);
        for (int i = 0; i < 8; i++) line(int'($urandom_range(479)));
        rand_pct = 100;
        for (int i = 0; i < 4; i++) line(int'($urandom_range(479)));
        rand_pct = 30;
        for (int r = 476; r < 482; r++) line(r);
        line(524);
        line(0);

        // Reset while a CPU write is being issued in a visible cycle.
        rand_pct = 0;
        drain(100);
        for (int i = 0; i < 21; i++) tick(i, 100);
        @(negedge clk);
        @(posedge clk);
        #1;
        x = 10'd21;
        present('{we: 1'b1, addr: 300, data: 3'b110, cond: 0});
        #1;
        chk("pre_rst_we", 32'(mem_we), 32'(1));
        enter_reset();
        #1;
        chk("async_we_drop", 32'(mem_we), 32'(0));
        chk("async_rgb_drop", 32'({RD, GD, BD}), 32'(0));
        chk("async_ack_low", 32'(cpu_ack), 32'(0));
        cpu_req = 1'b0;
        for (int i = 0; i < 3; i++) tick(i, 500);
        #1 rst_n = 1'b1;
        dq.push_back('{we: 1'b0, addr: 300, data: 3'b000, cond: 0});
        for (int i = 3; i < 40; i++) tick(i, 500);

        // Reset during the acknowledge cycle of a read.
        @(negedge clk);
        @(posedge clk);
        #1;
        x = 10'd700;
        present('{we: 1'b0, addr: 400, data: 3'b000, cond: 0});
        @(posedge clk);
        #1;
        x = 10'd701;
        #1;
        chk("pre_rst_ack", 32'(cpu_ack), 32'(1));
        enter_reset();
        #1;
        chk("async_ack_drop", 32'(cpu_ack), 32'(0));
        chk("async_rdata_drop", 32'(cpu_rdata), 32'(0));
        cpu_req = 1'b0;
        for (int i = 0; i < 3; i++) tick(i, 502);
        #1 rst_n = 1'b1;
        dq.push_back('{we: 1'b0, addr: 400, data: 3'b000, cond: 0});
        for (int i = 3; i < 40; i++) tick(i, 502);
        line(477);

        drain(503);
        for (int i = 0; i < 8; i++) tick(i, 503);
        chk("cpu_drained", 32'(cpu_req), 32'(0));
        chk("acks_outstanding", 32'(aq.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
